// File: rtl/sensor_dht_responder.sv
// Init/read command responder driving a DHT11/DHT22-style single-wire sensor over open-drain DQ.
// Optional macro SENSOR_DHT_CHECKSUM_EN: reject frames whose checksum byte does not match.
module sensor_dht_responder #(
    parameter int CYC_PER_US    = 50,
    parameter int INIT_WAIT_US  = 1000000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_init,
    input  logic        start_read,
    output logic        init_done,
    output logic        read_done,
    input  logic        dq_in,
    output logic        dq_oe,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        data_valid,
    output logic        read_err,
    output logic [3:0]  o_dbg_state
);
    localparam int PRE_W = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CYC_PER_US - 1);
    localparam logic [19:0]      INIT_CNT   = 20'(INIT_WAIT_US);
    localparam logic [19:0]      START_CNT  = 20'(START_LOW_US);
    localparam logic [19:0]      TO_CNT     = 20'(TIMEOUT_US);
    localparam logic [19:0]      THRESH_CNT = 20'(BIT_THRESH_US);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_WAIT, S_START_LOW, S_WAIT_ACK, S_ACK_LOW,
        S_ACK_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_dq_meta;
    logic             r_dq_sync;
    logic [PRE_W-1:0] r_pre;
    logic [19:0]      r_us;
    logic [5:0]       r_bit_idx;
    logic [39:0]      r_shift;
    logic             r_rel_seen;
    logic             r_init_armed;
    logic             r_read_armed;
    logic             r_init_done;
    logic             r_read_done;
    logic [15:0]      r_hum;
    logic [15:0]      r_tmp;
    logic             r_valid;
    logic             r_err;

    logic w_tick;
    logic w_dq;
    logic w_acc_init;
    logic w_acc_read;
    logic w_wait_state;
    logic w_timeout;
    logic w_init_fin;
    logic w_read_fin;
    logic w_bit_end;
    logic w_frame_ok;

    assign w_dq       = r_dq_sync;
    assign w_tick     = (r_pre == PRE_LAST);
    assign w_acc_init = (r_state == S_IDLE) && start_init && r_init_armed;
    assign w_acc_read = (r_state == S_IDLE) && start_read && r_read_armed && !w_acc_init;
    assign w_wait_state = (r_state == S_WAIT_ACK) || (r_state == S_ACK_LOW) ||
                          (r_state == S_ACK_HIGH) || (r_state == S_BIT_LOW) ||
                          (r_state == S_BIT_HIGH);

`ifdef SENSOR_DHT_CHECKSUM_EN
    logic [7:0] w_sum;
    assign w_sum      = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
    assign w_frame_ok = (w_sum == r_shift[7:0]);
`else
    assign w_frame_ok = 1'b1;
`endif

    always_comb begin
        w_next     = r_state;
        w_timeout  = 1'b0;
        w_init_fin = 1'b0;
        w_read_fin = 1'b0;
        w_bit_end  = 1'b0;
        if (w_wait_state && (r_us > TO_CNT)) begin
            w_next    = S_IDLE;
            w_timeout = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc_init)      w_next = S_INIT_WAIT;
                    else if (w_acc_read) w_next = S_START_LOW;
                end
                S_INIT_WAIT: begin
                    if (r_us >= INIT_CNT) begin
                        w_next     = S_IDLE;
                        w_init_fin = 1'b1;
                    end
                end
                S_START_LOW: if (r_us >= START_CNT) w_next = S_WAIT_ACK;
                // Our own low drive is still in the synchronizer at entry; wait to see the release first.
                S_WAIT_ACK: if (r_rel_seen && !w_dq) w_next = S_ACK_LOW;
                S_ACK_LOW:  if (w_dq)  w_next = S_ACK_HIGH;
                S_ACK_HIGH: if (!w_dq) w_next = S_BIT_LOW;
                S_BIT_LOW:  if (w_dq)  w_next = S_BIT_HIGH;
                S_BIT_HIGH: begin
                    if (!w_dq) begin
                        w_bit_end = 1'b1;
                        w_next    = (r_bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
                    end
                end
                S_CHECK: begin
                    w_next     = S_IDLE;
                    w_read_fin = 1'b1;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_dq_meta    <= 1'b1;
            r_dq_sync    <= 1'b1;
            r_pre        <= '0;
            r_us         <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_rel_seen   <= 1'b0;
            r_init_armed <= 1'b0;
            r_read_armed <= 1'b0;
            r_init_done  <= 1'b0;
            r_read_done  <= 1'b0;
            r_hum        <= '0;
            r_tmp        <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dq_meta <= dq_in;
            r_dq_sync <= r_dq_meta;
            r_pre     <= w_tick ? '0 : r_pre + 1'b1;

            if (w_next != r_state)            r_us <= '0;
            else if (w_tick && (r_us != '1))  r_us <= r_us + 1'b1;

            if (r_state != S_WAIT_ACK) r_rel_seen <= 1'b0;
            else if (w_dq)             r_rel_seen <= 1'b1;

            if ((r_state == S_ACK_HIGH) && (w_next == S_BIT_LOW)) r_bit_idx <= '0;
            else if (w_bit_end)                                   r_bit_idx <= r_bit_idx + 1'b1;
            if (w_bit_end) r_shift <= {r_shift[38:0], (r_us > THRESH_CNT)};

            // Arming is withdrawn at completion so a request still held afterwards is not re-served.
            if (w_init_fin)       r_init_armed <= 1'b0;
            else if (!start_init) r_init_armed <= 1'b1;
            if (w_read_fin || w_timeout) r_read_armed <= 1'b0;
            else if (!start_read)        r_read_armed <= 1'b1;

            r_init_done <= w_init_fin;
            r_read_done <= w_read_fin || w_timeout;

            if (w_acc_read)                                r_err <= 1'b0;
            else if (w_timeout)                            r_err <= 1'b1;
            else if ((r_state == S_CHECK) && !w_frame_ok)  r_err <= 1'b1;

            if ((r_state == S_CHECK) && w_frame_ok) begin
                r_hum   <= r_shift[39:24];
                r_tmp   <= r_shift[23:8];
                r_valid <= 1'b1;
            end
        end
    end

    assign dq_oe       = (r_state == S_START_LOW);
    assign init_done   = r_init_done;
    assign read_done   = r_read_done;
    assign humidity    = r_hum;
    assign temperature = r_tmp;
    assign data_valid  = r_valid;
    assign read_err    = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sensor_dht_responder.sv
// Randomized bench for sensor_dht_responder: open-drain sensor model, frame-level reference model, scoreboard.
`timescale 1ns/1ps
module tb_sensor_dht_responder;
    localparam int CYC = 4;
    localparam int W   = 35;  // {is_read, read_err, data_valid, humidity, temperature}
`ifdef SENSOR_DHT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_init = 1'b0;
    logic        start_read = 1'b0;
    logic        init_done, read_done, dq_in, dq_oe, data_valid, read_err;
    logic [15:0] humidity, temperature;
    logic [3:0]  dbg_state;
    logic        sens_low = 1'b0;

    assign dq_in = (dq_oe || sens_low) ? 1'b0 : 1'b1;

    sensor_dht_responder #(
        .CYC_PER_US(CYC), .INIT_WAIT_US(100), .START_LOW_US(20), .TIMEOUT_US(200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_init(start_init), .start_read(start_read),
        .init_done(init_done), .read_done(read_done), .dq_in(dq_in), .dq_oe(dq_oe),
        .humidity(humidity), .temperature(temperature), .data_valid(data_valid),
        .read_err(read_err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_init = 0;
    int n_read = 0;
    int last_done_cyc = 0;
    logic [W-1:0] exp_q[$];
    logic [15:0]  m_hum = '0;
    logic [15:0]  m_tmp = '0;
    logic         m_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference model works on whole frames: bytes in, register contents out.
    function automatic void push_read_exp(input logic [39:0] f, input bit silent);
        bit good;
        int s;
        good = 1'b0;
        if (!silent) begin
            s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
            good = !CHK_EN || ((s % 256) == int'(f[7:0]));
        end
        if (good) begin
            m_hum   = f[39:24];
            m_tmp   = f[23:8];
            m_valid = 1'b1;
        end
        exp_q.push_back({1'b1, !good, m_valid, m_hum, m_tmp});
    endfunction

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && (init_done || read_done)) begin
            if (init_done && read_done) bound_fail("done_overlap");
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, read_done, init_done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_kind", {31'd0, read_done}, {31'd0, e[34]});
                if (e[34]) begin
                    check("read_err",    {31'd0, read_err},   {31'd0, e[33]});
                    check("data_valid",  {31'd0, data_valid}, {31'd0, e[32]});
                    check("humidity",    {16'd0, humidity},   {16'd0, e[31:16]});
                    check("temperature", {16'd0, temperature},{16'd0, e[15:0]});
                end
            end
            if (init_done) n_init++;
            if (read_done) n_read++;
            last_done_cyc = cyc;
        end
    end

    task automatic wait_us(input int u);
        repeat (u * CYC) @(negedge clk);
    endtask

    task automatic sensor_respond(input logic [39:0] frame, input bit silent);
        int n;
        n = 0;
        while (!dq_oe && n < 5000) begin @(negedge clk); n++; end
        if (!dq_oe) begin bound_fail("host_start_low"); return; end
        n = 0;
        while (dq_oe && n < 1000) begin @(negedge clk); n++; end
        if (dq_oe) begin bound_fail("host_release"); return; end
        if (silent) return;
        wait_us(10);
        sens_low = 1'b1; wait_us(80);
        sens_low = 1'b0; wait_us(80);
        for (int i = 39; i >= 0; i--) begin
            sens_low = 1'b1; wait_us(12);
            sens_low = 1'b0; wait_us(frame[i] ? 60 : 20);
        end
        sens_low = 1'b1; wait_us(12);
        sens_low = 1'b0;
    endtask

    task automatic wait_read(input int base);
        int n;
        n = 0;
        while (n_read == base && n < 3000) begin @(negedge clk); n++; end
        if (n_read == base) bound_fail("read_done_wait");
    endtask

    task automatic do_read(input logic [39:0] frame, input bit silent, output int lat);
        int base, t0;
        push_read_exp(frame, silent);
        base = n_read;
        @(negedge clk);
        start_read = 1'b1;
        t0 = cyc;
        sensor_respond(frame, silent);
        wait_read(base);
        lat = last_done_cyc - t0;
        start_read = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    function automatic logic [39:0] make_frame(input bit corrupt);
        logic [7:0] b[4];
        logic [7:0] s;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
        s = b[0] + b[1] + b[2] + b[3];
        if (corrupt) s = s + 8'($urandom_range(1, 255));
        return {b[0], b[1], b[2], b[3], s};
    endfunction

    initial begin
        #(2_000_000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, t0, n, base_i, base_r;
        logic [39:0] f;

        repeat (5) @(negedge clk);
        check("rst_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("rst_done", {30'd0, init_done, read_done}, 32'd0);
        check("rst_data", {humidity, temperature}, 32'd0);
        check("rst_flags", {30'd0, data_valid, read_err}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dq_oe !== 1'b0) check("idle_dq_oe", {31'd0, dq_oe}, 32'd0);
        end
        check("post_rst_flags", {29'd0, dq_oe, data_valid, read_err}, 32'd0);

        // init: single pulse after ~100 us, no repeat while the request stays high
        exp_q.push_back({1'b1 ^ 1'b1, 1'b0, 1'b0, 32'd0});
        start_init = 1'b1;
        t0 = cyc;
        n = 0;
        while (n_init == 0 && n < 2000) begin @(negedge clk); n++; end
        if (n_init == 0) bound_fail("init_done_wait");
        lat = last_done_cyc - t0;
        check("init_latency_ok", {31'd0, (lat >= 396 && lat <= 406)}, 32'd1);
        repeat (600) @(negedge clk);
        check("init_single_pulse", n_init, 1);
        start_init = 1'b0;
        repeat (10) @(negedge clk);

        do_read({8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 1'b0, lat);
        do_read({8'h37, 8'h00, 8'h19, 8'h00, 8'h51}, 1'b0, lat);
        do_read(make_frame(1'b0), 1'b0, lat);
        do_read(make_frame($urandom_range(0, 1) == 1), 1'b0, lat);

        do_read(40'd0, 1'b1, lat);
        check("timeout_latency_ok", {31'd0, (lat >= 875 && lat <= 895)}, 32'd1);

        // init and read requested together: init served first, then the read
        f = make_frame(1'b0);
        exp_q.push_back({1'b0, 34'd0});
        push_read_exp(f, 1'b0);
        base_i = n_init;
        base_r = n_read;
        @(negedge clk);
        start_init = 1'b1;
        start_read = 1'b1;
        fork
            sensor_respond(f, 1'b0);
            begin
                n = 0;
                while (n_init == base_i && n < 2000) begin @(negedge clk); n++; end
                if (n_init == base_i) bound_fail("both_init_wait");
                check("both_read_not_yet_done", n_read, base_r);
                start_init = 1'b0;
            end
        join
        wait_read(base_r);
        start_read = 1'b0;
        repeat (20) @(negedge clk);

        // reset during the host start pulse aborts immediately
        start_read = 1'b1;
        n = 0;
        while (!dq_oe && n < 100) begin @(negedge clk); n++; end
        if (!dq_oe) bound_fail("abort_start_wait");
        wait_us(5);
        #1 rst_n = 1'b0;
        #1;
        check("abort_dq_oe", {31'd0, dq_oe}, 32'd0);
        check("abort_data", {humidity, temperature}, 32'd0);
        check("abort_flags", {28'd0, data_valid, read_err, init_done, read_done}, 32'd0);
        m_hum = '0; m_tmp = '0; m_valid = 1'b0;
        start_read = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (1200) @(negedge clk);
        check("abort_dq_oe_after", {31'd0, dq_oe}, 32'd0);

        check("read_done_count", n_read, 6);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
